clock_comp_sched: RTL and testbench

CLOCK_COMP_SCHED -- requirements
Module: clock_comp_sched

---
 rtl/clock_comp_pkg.sv | 18 +
 rtl/am_period_monitor.sv | 49 ++++
 rtl/clock_comp_sched.sv | 114 +++++++++++
 tb/tb_clock_comp_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_comp_pkg.sv
// Shared types and constants for the clock-compensation scheduler.
// Holds FSM encoding, the idle block pattern and control-bit defaults.
package clock_comp_pkg;

  typedef enum logic [1:0] {
    ST_PRIME   = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_PENDING = 2'd2,
    ST_INSERT  = 2'd3
  } cc_state_e;

  // 66b idle control block: sync header 10, type 0x1E, idle chars
  localparam logic [65:0] PCS_IDLE =
    {2'b10, 8'h1E, 56'h0};

  localparam int RX_C_IDX_DEF = 0;

endpackage

// File: rtl/am_period_monitor.sv
// Counts ticks over one AM window and checks the AM count per window.
// The AM seen on the last tick belongs to the window that is closing.
module am_period_monitor #(
  parameter int N_LANES         = 20,
  parameter int AM_BLOCK_PERIOD = 16383
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_sol_tag,
  output logic o_am_count_err
);

  localparam int PERIOD = AM_BLOCK_PERIOD * N_LANES;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW = $clog2(PERIOD + 1);

  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] am_cnt;
  logic [AW-1:0] am_total;
  logic          last;
  logic          err_q;

  assign last     = tick_cnt == TW'(PERIOD - 1);
  assign am_total = am_cnt + AW'(i_sol_tag);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt <= '0;
      am_cnt   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= i_tick & last
             & (am_total != AW'(N_LANES));
      if (i_tick) begin
        if (last) begin
          tick_cnt <= '0;
          am_cnt   <= '0;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
          am_cnt   <= am_total;
        end
      end
    end
  end

  assign o_am_count_err = err_q;

endmodule

// File: rtl/clock_comp_sched.sv
// Idle-insertion scheduler: earns credit on deleted AMs and spends it
// by muxing PCS_IDLE into the stream on RX_C control blocks.
module clock_comp_sched
  import clock_comp_pkg::*;
#(
  parameter int N_LANES           = 20,
  parameter int AM_BLOCK_PERIOD   = 16383,
  parameter int NB_ADDR           = 5,
  parameter int N_FSM_DECO_STATES = 4,
  parameter int RX_C_IDX          = RX_C_IDX_DEF,
  parameter int PRIME_LEVEL       = 20
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_rf_enable,
  input  logic                         i_valid,
  input  logic                         i_sol_tag,
  input  logic [N_FSM_DECO_STATES-1:0] i_fsm_control,
  input  logic                         i_fifo_empty,
  input  logic [NB_ADDR:0]             i_fifo_level,
  output logic                         o_fifo_wr_enb,
  output logic                         o_fifo_rd_enb,
  output logic                         o_idle_insert,
  output logic [NB_ADDR:0]             o_credit,
  output logic [1:0]                   o_state,
  output logic                         o_credit_ovf,
  output logic                         o_underrun,
  output logic                         o_am_count_err
);

  localparam int CW = NB_ADDR + 1;
  localparam logic [CW-1:0] CMAX = CW'(1) << NB_ADDR;
  localparam logic [CW-1:0] PLVL = CW'(PRIME_LEVEL);

  cc_state_e     state, state_nxt;
  logic [CW-1:0] credit, credit_nxt;
  logic          ovf_q, under_q;
  logic          tick, ctrl, sol_t;
  logic          hold, run;
  logic          ins, starve;
  logic          ovf_set;
  logic          unused_ctrl;

  assign tick  = i_rf_enable & i_valid;
  assign ctrl  = i_fsm_control[RX_C_IDX];
  assign sol_t = tick & i_sol_tag;

  assign unused_ctrl = ^i_fsm_control;

  // reset behaves like PRIME so an insertion stops on the same cycle
  assign hold   = i_reset | (state == ST_PRIME);
  assign run    = tick & ~hold;
  assign ins    = run & (credit != '0) & ctrl;
  assign starve = run & ~ins & i_fifo_empty;

  assign o_fifo_wr_enb = tick & ~i_sol_tag;
  assign o_fifo_rd_enb = run & ~ins & ~i_fifo_empty;
  assign o_idle_insert = ins | hold | starve;

  always_comb begin
    credit_nxt = credit;
    ovf_set    = 1'b0;
    if (sol_t & ~ins) begin
      if (credit == CMAX) ovf_set = 1'b1;
      else credit_nxt = credit + CW'(1);
    end else if (ins & ~sol_t) begin
      credit_nxt = credit - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_PRIME) begin
      if (i_fifo_level >= PLVL) state_nxt = ST_NORMAL;
    end else if (credit_nxt == '0) begin
      state_nxt = ST_NORMAL;
    end else if (ctrl) begin
      state_nxt = ST_INSERT;
    end else begin
      state_nxt = ST_PENDING;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= ST_PRIME;
      credit  <= '0;
      ovf_q   <= 1'b0;
      under_q <= 1'b0;
    end else if (tick) begin
      state   <= state_nxt;
      credit  <= credit_nxt;
      ovf_q   <= ovf_q | ovf_set;
      under_q <= under_q | starve;
    end
  end

  assign o_credit     = credit;
  assign o_state      = state;
  assign o_credit_ovf = ovf_q;
  assign o_underrun   = under_q;

  am_period_monitor #(
    .N_LANES         (N_LANES),
    .AM_BLOCK_PERIOD (AM_BLOCK_PERIOD)
  ) u_mon (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_tick         (tick),
    .i_sol_tag      (i_sol_tag),
    .o_am_count_err (o_am_count_err)
  );

endmodule

// File: tb/tb_clock_comp_sched.sv
// Bench for clock_comp_sched: directed scenarios plus random traffic
// against an integer-level model of credit, mode and AM windows.
module tb_clock_comp_sched;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rf_enable = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_sol_tag = 1'b0;
  logic [3:0] i_fsm_control = '0;
  logic       i_fifo_empty = 1'b0;
  logic [3:0] i_fifo_level = '0;
  logic       o_fifo_wr_enb, o_fifo_rd_enb, o_idle_insert;
  logic [3:0] o_credit;
  logic [1:0] o_state;
  logic       o_credit_ovf, o_underrun, o_am_count_err;

  int checks = 0;
  int failures = 0;

  // model: mode 0 prime, 1 normal, 2 pending, 3 insert
  int m_state = 0, m_credit = 0, m_win = 0, m_am = 0;
  bit m_ovf = 0, m_under = 0, m_err = 0;
  bit e_wr, e_rd, e_idle;
  logic obs_wr, obs_rd, obs_idle;

  clock_comp_sched #(
    .N_LANES(4), .AM_BLOCK_PERIOD(8),
    .NB_ADDR(3), .N_FSM_DECO_STATES(4),
    .RX_C_IDX(0), .PRIME_LEVEL(4)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rf_enable(i_rf_enable), .i_valid(i_valid),
    .i_sol_tag(i_sol_tag), .i_fsm_control(i_fsm_control),
    .i_fifo_empty(i_fifo_empty), .i_fifo_level(i_fifo_level),
    .o_fifo_wr_enb(o_fifo_wr_enb), .o_fifo_rd_enb(o_fifo_rd_enb),
    .o_idle_insert(o_idle_insert), .o_credit(o_credit),
    .o_state(o_state), .o_credit_ovf(o_credit_ovf),
    .o_underrun(o_underrun), .o_am_count_err(o_am_count_err)
  );

  always #5 i_clock = ~i_clock;

  task automatic step(input bit rst, input bit en, input bit vld,
                      input bit sol, input bit ctl, input bit emp,
                      input int lvl);
    bit tk, prm, ins, stv;
    int nc;
    logic [3:0] fc;
    fc = 4'($urandom);
    fc[0] = ctl;
    i_reset = rst; i_rf_enable = en; i_valid = vld;
    i_sol_tag = sol; i_fsm_control = fc;
    i_fifo_empty = emp; i_fifo_level = 4'(lvl);
    #1;
    tk  = en && vld;
    prm = rst || (m_state == 0);
    ins = tk && !prm && (m_credit > 0) && ctl;
    stv = tk && !prm && !ins && emp;
    e_wr   = tk && !sol;
    e_rd   = tk && !prm && !ins && !emp;
    e_idle = ins || prm || stv;
    obs_wr = o_fifo_wr_enb;
    obs_rd = o_fifo_rd_enb;
    obs_idle = o_idle_insert;
    @(posedge i_clock);
    #1;
    m_err = 0;
    if (rst) begin
      m_state = 0; m_credit = 0; m_win = 0; m_am = 0;
      m_ovf = 0; m_under = 0;
    end else if (tk) begin
      nc = m_credit + int'(sol) - int'(ins);
      if (nc > 8) begin nc = 8; m_ovf = 1; end
      if (stv) m_under = 1;
      if (m_state == 0) m_state = (lvl >= 4) ? 1 : 0;
      else if (nc == 0) m_state = 1;
      else m_state = ctl ? 3 : 2;
      m_credit = nc;
      if (m_win == 31) begin
        m_err = (m_am + int'(sol)) != 4;
        m_win = 0; m_am = 0;
      end else begin
        m_win++; m_am += int'(sol);
      end
    end
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 1, 0, 8);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", o_state); end
    checks++; if (o_credit !== 4'd0) begin failures++; $display("FAIL rst_credit got=%0d exp=0", o_credit); end
    checks++; if ({o_credit_ovf, o_underrun, o_am_count_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {o_credit_ovf, o_underrun, o_am_count_err}); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if ({obs_idle, obs_rd} !== 2'b10) begin failures++; $display("FAIL rst_idle_rd got=%b exp=10", {obs_idle, obs_rd}); end
  endtask

  task automatic test_prime();
    for (int l = 0; l <= 4; l++) begin
      step(0, 1, 1, 0, 0, 0, l);
      checks++; if ({obs_idle, obs_rd} !== 2'b10) begin failures++; $display("FAIL prime_out lvl=%0d got=%b exp=10", l, {obs_idle, obs_rd}); end
      checks++; if (o_state !== ((l < 4) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL prime_state lvl=%0d got=%0d", l, o_state); end
    end
  endtask

  task automatic test_credit();
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 1, 0, 0, 6);
      checks++; if (obs_wr !== 1'b0) begin failures++; $display("FAIL am_wr k=%0d got=%0b exp=0", k, obs_wr); end
    end
    checks++; if (o_credit !== 4'd4 || o_state !== 2'd2) begin failures++; $display("FAIL earn got=%0d/%0d exp=4/2", o_credit, o_state); end
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 0, 1, 0, 6);
      checks++; if ({obs_idle, obs_rd} !== 2'b10) begin failures++; $display("FAIL spend k=%0d got=%b exp=10", k, {obs_idle, obs_rd}); end
    end
    checks++; if (o_credit !== 4'd0 || o_state !== 2'd1) begin failures++; $display("FAIL drained got=%0d/%0d exp=0/1", o_credit, o_state); end
  endtask

  task automatic test_am_insert();
    step(0, 1, 1, 1, 0, 0, 6);
    step(0, 1, 1, 1, 0, 0, 6);
    step(0, 1, 1, 1, 1, 0, 6);
    checks++; if ({obs_idle, obs_rd} !== 2'b10) begin failures++; $display("FAIL amins_out got=%b exp=10", {obs_idle, obs_rd}); end
    checks++; if (o_credit !== 4'd2 || o_state !== 2'd3) begin failures++; $display("FAIL amins got=%0d/%0d exp=2/3", o_credit, o_state); end
    step(0, 1, 1, 0, 1, 0, 6);
    step(0, 1, 1, 0, 1, 0, 6);
    checks++; if (o_credit !== 4'd0 || o_state !== 2'd1) begin failures++; $display("FAIL amins_drain got=%0d/%0d exp=0/1", o_credit, o_state); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 8; k++) step(0, 1, 1, 1, 0, 0, 6);
    checks++; if (o_credit !== 4'd8 || o_credit_ovf !== 1'b0) begin failures++; $display("FAIL sat8 got=%0d/%0b exp=8/0", o_credit, o_credit_ovf); end
    step(0, 1, 1, 1, 0, 0, 6);
    checks++; if (o_credit !== 4'd8 || o_credit_ovf !== 1'b1) begin failures++; $display("FAIL sat9 got=%0d/%0b exp=8/1", o_credit, o_credit_ovf); end
    for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 1, 0, 6);
    checks++; if (o_credit !== 4'd0 || o_credit_ovf !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0d/%0b exp=0/1", o_credit, o_credit_ovf); end
  endtask

  task automatic test_window();
    bit sol;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      sol = (i == 5) || (i == 10) || (i == 20);
      step(0, 1, 1, sol, 0, 0, 8);
      if (i >= 30) begin
        checks++; if (o_am_count_err !== (i == 32)) begin failures++; $display("FAIL win3 tick=%0d got=%0b", i, o_am_count_err); end
      end
    end
    step(0, 0, 1, 0, 0, 0, 8);
    checks++; if (o_am_count_err !== 1'b0) begin failures++; $display("FAIL win_pulse got=%0b exp=0", o_am_count_err); end
    for (int i = 2; i <= 32; i++) begin
      sol = (i == 2) || (i == 9) || (i == 17) || (i == 32);
      step(0, 1, 1, sol, 0, 0, 8);
    end
    step(0, 1, 1, 0, 0, 0, 8);
    checks++; if (o_am_count_err !== 1'b0) begin failures++; $display("FAIL win4 got=%0b exp=0", o_am_count_err); end
  endtask

  task automatic test_underrun();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 8);
    step(0, 1, 1, 0, 0, 1, 0);
    checks++; if ({obs_idle, obs_rd} !== 2'b10) begin failures++; $display("FAIL starve_out got=%b exp=10", {obs_idle, obs_rd}); end
    checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL underrun got=%0b exp=1", o_underrun); end
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0, 0, 6);
    step(0, 1, 1, 0, 1, 0, 6);
    checks++; if (o_state !== 2'd3 || o_credit !== 4'd2) begin failures++; $display("FAIL ins_mid got=%0d/%0d exp=3/2", o_state, o_credit); end
    step(1, 1, 1, 0, 1, 0, 6);
    checks++; if ({obs_wr, obs_rd} !== 2'b10) begin failures++; $display("FAIL rst_ins_out got=%b exp=10", {obs_wr, obs_rd}); end
    checks++; if (o_state !== 2'd0 || o_credit !== 4'd0) begin failures++; $display("FAIL rst_ins got=%0d/%0d exp=0/0", o_state, o_credit); end
  endtask

  task automatic test_random();
    bit rst, en, vld, sol, ctl, emp;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 149) == 0;
      en  = $urandom_range(0, 7) != 0;
      vld = $urandom_range(0, 7) != 0;
      sol = $urandom_range(0, 7) == 0;
      ctl = $urandom_range(0, 1) == 1;
      emp = $urandom_range(0, 7) == 0;
      step(rst, en, vld, sol, ctl, emp, $urandom_range(0, 8));
      checks++; if ({obs_wr, obs_rd, obs_idle} !== {e_wr, e_rd, e_idle}) begin failures++; $display("FAIL rnd_comb i=%0d got=%b exp=%b", i, {obs_wr, obs_rd, obs_idle}, {e_wr, e_rd, e_idle}); end
      checks++; if (o_credit !== 4'(m_credit) || o_state !== 2'(m_state)) begin failures++; $display("FAIL rnd_reg i=%0d got=%0d/%0d exp=%0d/%0d", i, o_credit, o_state, m_credit, m_state); end
      checks++; if ({o_credit_ovf, o_underrun, o_am_count_err} !== {m_ovf, m_under, m_err}) begin failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {o_credit_ovf, o_underrun, o_am_count_err}, {m_ovf, m_under, m_err}); end
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_credit();
    test_am_insert();
    test_saturate();
    test_window();
    test_underrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
